// File: rtl/truco_mao_sequencer.sv
// truco_mao_sequencer: runs one truco hand (mao). It collects one card per
// player per trick, resolves best-of-three with the tie rules, arbitrates
// raises 1->3->6->9->12 and emits a single v1/v2/e strobe with the hand value P.
// Optional build macro RAISE_ALT_EN: the player who made the last accepted
// raise may not raise again; only the opponent may re-raise.
module truco_mao_sequencer #(
  parameter int RANK_W = 4,
  parameter int MAX_P  = 12
) (
  input  logic              CLK,
  input  logic              Clr,
  input  logic              Start,
  input  logic [RANK_W-1:0] C1,
  input  logic [RANK_W-1:0] C2,
  input  logic              Play1,
  input  logic              Play2,
  input  logic              T1,
  input  logic              T2,
  input  logic              Acc,
  input  logic              Run,
  output logic              v1,
  output logic              v2,
  output logic              e,
  output logic [3:0]        P,
  output logic              Busy,
  output logic              Pend,
  output logic [1:0]        Trick
);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CMP, S_PEND, S_DONE} state_t;
  typedef enum logic [1:0] {R_NONE, R_W1, R_W2, R_TIE} res_t;

  localparam logic [3:0] MAX_PV = 4'(MAX_P);

  state_t            state, state_nxt;
  logic [3:0]        p_val, p_nxt;
  logic [1:0]        trick, trick_nxt;
  logic              got1, got1_nxt, got2, got2_nxt;
  logic [RANK_W-1:0] card1, card1_nxt, card2, card2_nxt;
  res_t              hist0, hist0_nxt, hist1, hist1_nxt;
  res_t              outcome, outcome_nxt;
  logic              raiser, raiser_nxt;

  res_t              cmp_res;
  logic [2:0]        dres;
  logic              dec_c;
  res_t              win_c;
  logic              raise_req, req_p2, raise_ok, alt_ok;

  function automatic res_t rank_cmp(input logic [RANK_W-1:0] a, input logic [RANK_W-1:0] b);
    if (a > b)      return R_W1;
    else if (b > a) return R_W2;
    else            return R_TIE;
  endfunction

  // Hand decision after the trick with index t; returns {decided, winner}.
  // Undecided histories reaching trick 2 are only (TIE,TIE) and (X,Y).
  function automatic logic [2:0] decide(input logic [1:0] t, input res_t h0,
                                        input res_t h1, input res_t r);
    logic dec;
    res_t w;
    dec = 1'b0;
    w   = R_NONE;
    case (t)
      2'd1: begin
        if (h0 == R_TIE) begin
          if (r != R_TIE) begin
            dec = 1'b1;
            w   = r;
          end
        end else if (r == R_TIE || r == h0) begin
          dec = 1'b1;
          w   = h0;
        end
      end
      2'd2: begin
        dec = 1'b1;
        if (h0 == R_TIE && h1 == R_TIE) w = r;
        else                             w = (r == R_TIE) ? h0 : r;
      end
      default: ;
    endcase
    return {dec, w};
  endfunction

  function automatic logic [3:0] next_value(input logic [3:0] p);
    case (p)
      4'd1:    return 4'd3;
      4'd3:    return 4'd6;
      4'd6:    return 4'd9;
      4'd9:    return 4'd12;
      default: return p;
    endcase
  endfunction

  assign cmp_res   = rank_cmp(card1, card2);
  assign dres      = decide(trick, hist0, hist1, cmp_res);
  assign dec_c     = dres[2];
  assign win_c     = res_t'(dres[1:0]);
  assign raise_req = T1 ^ T2;
  assign req_p2    = T2;
  assign raise_ok  = raise_req && (p_val < MAX_PV) && alt_ok;

`ifdef RAISE_ALT_EN
  logic last_vld;
  logic last_raiser;
  // Remember who made the last accepted raise; forgotten at a new hand
  always_ff @(posedge CLK) begin
    if (Clr || (state == S_IDLE && Start)) begin
      last_vld    <= 1'b0;
      last_raiser <= 1'b0;
    end else if (state == S_PEND && Acc && !Run) begin
      last_vld    <= 1'b1;
      last_raiser <= raiser;
    end
  end
  assign alt_ok = !(last_vld && (last_raiser == req_p2));
`else
  assign alt_ok = 1'b1;
`endif

  // State and hand-context registers; Clr clears everything
  always_ff @(posedge CLK) begin
    if (Clr) begin
      state   <= S_IDLE;
      p_val   <= 4'd0;
      trick   <= 2'd0;
      got1    <= 1'b0;
      got2    <= 1'b0;
      card1   <= '0;
      card2   <= '0;
      hist0   <= R_NONE;
      hist1   <= R_NONE;
      outcome <= R_NONE;
      raiser  <= 1'b0;
    end else begin
      state   <= state_nxt;
      p_val   <= p_nxt;
      trick   <= trick_nxt;
      got1    <= got1_nxt;
      got2    <= got2_nxt;
      card1   <= card1_nxt;
      card2   <= card2_nxt;
      hist0   <= hist0_nxt;
      hist1   <= hist1_nxt;
      outcome <= outcome_nxt;
      raiser  <= raiser_nxt;
    end
  end

  // Next-state logic: card collection, raise arbitration and trick resolution
  always_comb begin
    state_nxt   = state;
    p_nxt       = p_val;
    trick_nxt   = trick;
    got1_nxt    = got1;
    got2_nxt    = got2;
    card1_nxt   = card1;
    card2_nxt   = card2;
    hist0_nxt   = hist0;
    hist1_nxt   = hist1;
    outcome_nxt = outcome;
    raiser_nxt  = raiser;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nxt   = S_PLAY;
          p_nxt       = 4'd1;
          trick_nxt   = 2'd0;
          got1_nxt    = 1'b0;
          got2_nxt    = 1'b0;
          card1_nxt   = '0;
          card2_nxt   = '0;
          hist0_nxt   = R_NONE;
          hist1_nxt   = R_NONE;
          outcome_nxt = R_NONE;
          raiser_nxt  = 1'b0;
        end
      end
      S_PLAY: begin
        if (raise_ok) begin
          // An accepted raise takes the cycle; card strobes alongside it are dropped
          state_nxt  = S_PEND;
          raiser_nxt = req_p2;
        end else begin
          if (Play1 && !got1) begin
            got1_nxt  = 1'b1;
            card1_nxt = C1;
          end
          if (Play2 && !got2) begin
            got2_nxt  = 1'b1;
            card2_nxt = C2;
          end
          if ((got1 || Play1) && (got2 || Play2)) state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (trick == 2'd0) hist0_nxt = cmp_res;
        if (trick == 2'd1) hist1_nxt = cmp_res;
        if (dec_c) begin
          outcome_nxt = win_c;
          state_nxt   = S_DONE;
        end else begin
          trick_nxt = trick + 2'd1;
          got1_nxt  = 1'b0;
          got2_nxt  = 1'b0;
          state_nxt = S_PLAY;
        end
      end
      S_PEND: begin
        if (Acc && !Run) begin
          p_nxt     = next_value(p_val);
          state_nxt = S_PLAY;
        end else if (Run && !Acc) begin
          outcome_nxt = raiser ? R_W2 : R_W1;
          state_nxt   = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign v1    = (state == S_DONE) && (outcome == R_W1);
  assign v2    = (state == S_DONE) && (outcome == R_W2);
  assign e     = (state == S_DONE) && (outcome == R_TIE);
  assign P     = p_val;
  assign Busy  = (state == S_PLAY) || (state == S_CMP) || (state == S_PEND);
  assign Pend  = (state == S_PEND);
  assign Trick = trick;

endmodule

// File: tb/tb_truco_mao_sequencer.sv
// Testbench for truco_mao_sequencer: directed scenarios plus randomized hands
// checked against a rule-level model of the hand outcome.
module tb_truco_mao_sequencer;

  logic       CLK = 1'b0;
  logic       Clr, Start, Play1, Play2, T1, T2, Acc, Run;
  logic [3:0] C1, C2;
  logic       v1, v2, e, Busy, Pend;
  logic [3:0] P;
  logic [1:0] Trick;

  int checks   = 0;
  int failures = 0;

  truco_mao_sequencer dut (
    .CLK(CLK), .Clr(Clr), .Start(Start), .C1(C1), .C2(C2),
    .Play1(Play1), .Play2(Play2), .T1(T1), .T2(T2), .Acc(Acc), .Run(Run),
    .v1(v1), .v2(v2), .e(e), .P(P), .Busy(Busy), .Pend(Pend), .Trick(Trick)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_hand();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Both cards in one cycle; on return the DUT is comparing the trick
  task automatic put_trick(input logic [3:0] a, input logic [3:0] b);
    C1 = a; C2 = b; Play1 = 1'b1; Play2 = 1'b1;
    tick();
    Play1 = 1'b0; Play2 = 1'b0;
  endtask

  // Outcome from the game rules: 0 undecided, 1 player 1, 2 player 2, 3 draw.
  // r[i]: 0 tie, 1 player-1 win, 2 player-2 win.
  function automatic int ref_hand(input int n, input int r[3]);
    int w1, w2;
    w1 = 0; w2 = 0;
    for (int i = 0; i < n; i++) begin
      if (r[i] == 1) w1++;
      if (r[i] == 2) w2++;
    end
    if (w1 >= 2) return 1;
    if (w2 >= 2) return 2;
    if (r[0] == 0) begin
      for (int i = 1; i < n; i++) if (r[i] != 0) return r[i];
      return (n == 3) ? 3 : 0;
    end
    for (int i = 1; i < n; i++) if (r[i] == 0) return r[0];
    return 0;
  endfunction

  task automatic test_reset();
    Clr = 1'b1;
    tick(); tick();
    Clr = 1'b0;
    checks++;
    if ({v1, v2, e, P, Busy, Pend, Trick} !== 11'b0) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", {v1, v2, e, P, Busy, Pend, Trick}, 11'b0);
    end
    Play1 = 1'b1; Play2 = 1'b1; T1 = 1'b1; Acc = 1'b1; Run = 1'b1;
    tick();
    Play1 = 1'b0; Play2 = 1'b0; T1 = 1'b0; Acc = 1'b0; Run = 1'b0;
    checks++;
    if ({v1, v2, e, P, Busy, Pend, Trick} !== 11'b0) begin
      failures++;
      $display("FAIL idle_ignore got=%b exp=%b", {v1, v2, e, P, Busy, Pend, Trick}, 11'b0);
    end
  endtask

  task automatic test_two_wins();
    begin_hand();
    checks++;
    if ({P, Busy, Pend, Trick} !== {4'd1, 1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL start got=%b exp=%b", {P, Busy, Pend, Trick}, {4'd1, 1'b1, 1'b0, 2'd0});
    end
    put_trick(4'd9, 4'd3);
    tick();
    checks++;
    if ({v1, v2, e, Busy, Trick} !== {3'b000, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL trick0_next got=%b exp=%b", {v1, v2, e, Busy, Trick}, {3'b000, 1'b1, 2'd1});
    end
    put_trick(4'd7, 4'd2);
    checks++;
    if ({v1, v2, e, Busy} !== 4'b0001) begin
      failures++;
      $display("FAIL cmp_cycle got=%b exp=%b", {v1, v2, e, Busy}, 4'b0001);
    end
    tick();
    checks++;
    if ({v1, v2, e, P, Busy, Trick} !== {3'b100, 4'd1, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL two_wins_strobe got=%b exp=%b", {v1, v2, e, P, Busy, Trick}, {3'b100, 4'd1, 1'b0, 2'd1});
    end
    tick();
    checks++;
    if ({v1, v2, e, P, Busy} !== {3'b000, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL two_wins_after got=%b exp=%b", {v1, v2, e, P, Busy}, {3'b000, 4'd1, 1'b0});
    end
  endtask

  task automatic test_tie_rules();
    begin_hand();
    put_trick(4'd5, 4'd5); tick();
    put_trick(4'd4, 4'd8); tick();
    checks++;
    if ({v1, v2, e, P, Busy} !== {3'b010, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL tie_then_win got=%b exp=%b", {v1, v2, e, P, Busy}, {3'b010, 4'd1, 1'b0});
    end
    tick();
    begin_hand();
    put_trick(4'd6, 4'd6); tick();
    put_trick(4'd6, 4'd6); tick();
    checks++;
    if ({v1, v2, e, Busy, Trick} !== {3'b000, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL two_ties_continue got=%b exp=%b", {v1, v2, e, Busy, Trick}, {3'b000, 1'b1, 2'd2});
    end
    put_trick(4'd6, 4'd6); tick();
    checks++;
    if ({v1, v2, e, P, Busy} !== {3'b001, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL three_ties got=%b exp=%b", {v1, v2, e, P, Busy}, {3'b001, 4'd1, 1'b0});
    end
    tick();
  endtask

  task automatic test_raises();
    logic [3:0] ladder [4];
    ladder[0] = 4'd3; ladder[1] = 4'd6; ladder[2] = 4'd9; ladder[3] = 4'd12;
    begin_hand();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) T1 = 1'b1; else T2 = 1'b1;
      tick();
      T1 = 1'b0; T2 = 1'b0;
      checks++;
      if (Pend !== 1'b1) begin
        failures++;
        $display("FAIL raise_pend%0d got=%b exp=1", i, Pend);
      end
      Acc = 1'b1;
      tick();
      Acc = 1'b0;
      checks++;
      if ({P, Pend} !== {ladder[i], 1'b0}) begin
        failures++;
        $display("FAIL raise_value%0d got=%b exp=%b", i, {P, Pend}, {ladder[i], 1'b0});
      end
    end
    T1 = 1'b1;
    tick();
    T1 = 1'b0;
    checks++;
    if ({P, Pend} !== {4'd12, 1'b0}) begin
      failures++;
      $display("FAIL raise_ceiling got=%b exp=%b", {P, Pend}, {4'd12, 1'b0});
    end
    put_trick(4'd1, 4'd9); tick();
    put_trick(4'd2, 4'd9); tick();
    checks++;
    if ({v1, v2, e, P} !== {3'b010, 4'd12}) begin
      failures++;
      $display("FAIL raised_hand got=%b exp=%b", {v1, v2, e, P}, {3'b010, 4'd12});
    end
    tick();
  endtask

  task automatic test_run();
    begin_hand();
    T1 = 1'b1; tick(); T1 = 1'b0;
    Acc = 1'b1; tick(); Acc = 1'b0;
    T2 = 1'b1; tick(); T2 = 1'b0;
    C1 = 4'd9; C2 = 4'd1; Play1 = 1'b1; Play2 = 1'b1; Acc = 1'b1; Run = 1'b1;
    tick();
    Play1 = 1'b0; Play2 = 1'b0; Acc = 1'b0; Run = 1'b0;
    checks++;
    if ({P, Pend, Busy} !== {4'd3, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pend_ignores got=%b exp=%b", {P, Pend, Busy}, {4'd3, 1'b1, 1'b1});
    end
    Run = 1'b1; tick(); Run = 1'b0;
    checks++;
    if ({v1, v2, e, P, Busy, Pend} !== {3'b010, 4'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL run_strobe got=%b exp=%b", {v1, v2, e, P, Busy, Pend}, {3'b010, 4'd3, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if ({v1, v2, e, P, Busy} !== {3'b000, 4'd3, 1'b0}) begin
      failures++;
      $display("FAIL run_after got=%b exp=%b", {v1, v2, e, P, Busy}, {3'b000, 4'd3, 1'b0});
    end
  endtask

  task automatic test_clr_mid();
    begin_hand();
    put_trick(4'd9, 4'd3); tick();
    Clr = 1'b1; tick(); Clr = 1'b0;
    checks++;
    if ({v1, v2, e, P, Busy, Pend, Trick} !== 11'b0) begin
      failures++;
      $display("FAIL clr_mid got=%b exp=%b", {v1, v2, e, P, Busy, Pend, Trick}, 11'b0);
    end
    begin_hand();
    checks++;
    if ({P, Busy, Pend, Trick} !== {4'd1, 1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL clr_restart got=%b exp=%b", {P, Busy, Pend, Trick}, {4'd1, 1'b1, 1'b0, 2'd0});
    end
    put_trick(4'd2, 4'd8); tick();
    put_trick(4'd2, 4'd8); tick();
    checks++;
    if ({v1, v2, e, P} !== {3'b010, 4'd1}) begin
      failures++;
      $display("FAIL clr_hand got=%b exp=%b", {v1, v2, e, P}, {3'b010, 4'd1});
    end
    tick();
  endtask

  task automatic test_alt();
    logic       exp_pend2;
    logic [3:0] exp_p;
`ifdef RAISE_ALT_EN
    exp_pend2 = 1'b0;
    exp_p     = 4'd6;
`else
    exp_pend2 = 1'b1;
    exp_p     = 4'd9;
`endif
    begin_hand();
    // card strobe together with an accepted raise must be dropped
    T1 = 1'b1; C1 = 4'd15; Play1 = 1'b1;
    tick();
    T1 = 1'b0; Play1 = 1'b0;
    Acc = 1'b1; tick(); Acc = 1'b0;
    T1 = 1'b1; tick(); T1 = 1'b0;
    checks++;
    if (Pend !== exp_pend2) begin
      failures++;
      $display("FAIL same_player_reraise got=%b exp=%b", Pend, exp_pend2);
    end
    if (Pend) begin
      Acc = 1'b1; tick(); Acc = 1'b0;
    end
    T2 = 1'b1; tick(); T2 = 1'b0;
    checks++;
    if (Pend !== 1'b1) begin
      failures++;
      $display("FAIL opponent_reraise got=%b exp=1", Pend);
    end
    Acc = 1'b1; tick(); Acc = 1'b0;
    put_trick(4'd3, 4'd9); tick();
    put_trick(4'd3, 4'd9); tick();
    checks++;
    if ({v1, v2, e, P} !== {3'b010, exp_p}) begin
      failures++;
      $display("FAIL alt_hand got=%b exp=%b", {v1, v2, e, P}, {3'b010, exp_p});
    end
    tick();
  endtask

  task automatic test_random();
    int         res [3];
    int         outcome, mp, last, who, ans, mode;
    bit         done, exp_pend;
    logic [3:0] a, b;
    for (int h = 0; h < 40; h++) begin
      begin_hand();
      mp = 1; last = 0; done = 0;
      res = '{0, 0, 0};
      checks++;
      if ({v1, v2, e, P, Busy, Pend, Trick} !== {3'b000, 4'd1, 1'b1, 1'b0, 2'd0}) begin
        failures++;
        $display("FAIL rnd_start h=%0d got=%b", h, {v1, v2, e, P, Busy, Pend, Trick});
      end
      for (int t = 0; t < 3 && !done; t++) begin
        if ($urandom_range(0, 2) == 0) begin
          who = $urandom_range(1, 3);
          T1 = (who != 2); T2 = (who != 1);
          tick();
          T1 = 1'b0; T2 = 1'b0;
          exp_pend = (who != 3) && (mp < 12);
`ifdef RAISE_ALT_EN
          if (who == last) exp_pend = 1'b0;
`endif
          checks++;
          if (Pend !== exp_pend) begin
            failures++;
            $display("FAIL rnd_pend h=%0d got=%b exp=%b", h, Pend, exp_pend);
          end
          if (exp_pend) begin
            ans = $urandom_range(0, 2);
            if (ans == 2) begin
              Acc = 1'b1; Run = 1'b1; tick(); Acc = 1'b0; Run = 1'b0;
              checks++;
              if (Pend !== 1'b1) begin
                failures++;
                $display("FAIL rnd_acc_run h=%0d got=%b exp=1", h, Pend);
              end
              ans = $urandom_range(0, 1);
            end
            if (ans == 0) begin
              Acc = 1'b1; Play1 = 1'b1; C1 = 4'($urandom_range(0, 15));
              tick();
              Acc = 1'b0; Play1 = 1'b0;
              mp = (mp == 1) ? 3 : mp + 3;
              last = who;
              checks++;
              if ({P, Pend} !== {4'(mp), 1'b0}) begin
                failures++;
                $display("FAIL rnd_accept h=%0d got=%b exp=%b", h, {P, Pend}, {4'(mp), 1'b0});
              end
            end else begin
              Run = 1'b1; tick(); Run = 1'b0;
              checks++;
              if ({v1, v2, e, P, Busy, Pend} !== {who == 1, who == 2, 1'b0, 4'(mp), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rnd_run h=%0d got=%b exp=%b", h, {v1, v2, e, P, Busy, Pend},
                         {who == 1, who == 2, 1'b0, 4'(mp), 1'b0, 1'b0});
              end
              tick();
              done = 1;
            end
          end
        end
        if (!done) begin
          a = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 6));
          b = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 6));
          mode = $urandom_range(0, 2);
          if (mode == 0) begin
            put_trick(a, b);
          end else if (mode == 1) begin
            C1 = a; Play1 = 1'b1; tick();
            C1 = ~a; C2 = b; Play2 = 1'b1; tick();
            Play1 = 1'b0; Play2 = 1'b0;
          end else begin
            C2 = b; Play2 = 1'b1; tick();
            C2 = ~b; C1 = a; Play1 = 1'b1; tick();
            Play1 = 1'b0; Play2 = 1'b0;
          end
          res[t] = (a > b) ? 1 : ((b > a) ? 2 : 0);
          tick();
          outcome = ref_hand(t + 1, res);
          if (outcome != 0) begin
            checks++;
            if ({v1, v2, e, P, Busy, Pend, Trick} !==
                {outcome == 1, outcome == 2, outcome == 3, 4'(mp), 1'b0, 1'b0, 2'(t)}) begin
              failures++;
              $display("FAIL rnd_result h=%0d t=%0d got=%b exp=%b", h, t, {v1, v2, e, P, Busy, Pend, Trick},
                       {outcome == 1, outcome == 2, outcome == 3, 4'(mp), 1'b0, 1'b0, 2'(t)});
            end
            tick();
            checks++;
            if ({v1, v2, e, Busy} !== 4'b0000) begin
              failures++;
              $display("FAIL rnd_single_strobe h=%0d got=%b exp=0000", h, {v1, v2, e, Busy});
            end
            done = 1;
          end else begin
            checks++;
            if ({v1, v2, e, P, Busy, Pend, Trick} !== {3'b000, 4'(mp), 1'b1, 1'b0, 2'(t + 1)}) begin
              failures++;
              $display("FAIL rnd_continue h=%0d t=%0d got=%b exp=%b", h, t, {v1, v2, e, P, Busy, Pend, Trick},
                       {3'b000, 4'(mp), 1'b1, 1'b0, 2'(t + 1)});
            end
          end
        end
      end
    end
  endtask

  initial begin
    Clr = 1'b1; Start = 1'b0; Play1 = 1'b0; Play2 = 1'b0;
    T1 = 1'b0; T2 = 1'b0; Acc = 1'b0; Run = 1'b0; C1 = 4'd0; C2 = 4'd0;
    test_reset();
    test_two_wins();
    test_tie_rules();
    test_raises();
    test_run();
    test_clr_mid();
    test_alt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
